// File: rtl/div_unit_pkg.sv
// Shared types and decode helpers for the RV64M iterative divider.
package div_unit_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned WLEN  = 32;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {
        DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
    } divop_t;

    typedef enum logic [1:0] {
        IDLE, RUN, FIX, DONE
    } state_t;

    function automatic logic is_signed(input divop_t op);
        return (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
    endfunction

    function automatic logic is_rem(input divop_t op);
        return (op == REM) || (op == REMU) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_word(input divop_t op);
        return (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left and trial-subtract the divisor.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Partial remainder is always below the divisor, so bit XLEN of the difference is the borrow.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_rem   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/div_unit.sv
// RV64M divide/remainder unit: radix-2 restoring loop with early-out for divide-by-zero and overflow.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  divop_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);

    state_t             r_state;
    divop_t             r_op;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_word;
    logic               w_sgn;
    logic [XLEN-1:0]    w_a_eff;
    logic [XLEN-1:0]    w_b_eff;
    logic [XLEN-1:0]    w_min;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_spec_sel;
    logic [XLEN-1:0]    w_spec_res;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [XLEN-1:0]    w_nrem;
    logic [XLEN-1:0]    w_nquo;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;
    logic [XLEN-1:0]    w_fix_sel;
    logic [XLEN-1:0]    w_fix_res;

    // Acceptance-time decode: effective operands, special cases and magnitudes.
    assign w_word  = is_word(op);
    assign w_sgn   = is_signed(op);
    assign w_a_eff = !w_word ? a : (w_sgn ? sext_word(a[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]});
    assign w_b_eff = !w_word ? b : (w_sgn ? sext_word(b[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]});
    assign w_min   = w_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0  = (w_b_eff == '0);
    assign w_ovf   = w_sgn && (w_a_eff == w_min) && (&w_b_eff);

    assign w_spec_sel = is_rem(op) ? (w_div0 ? w_a_eff : '0) : (w_div0 ? '1 : w_a_eff);
    assign w_spec_res = w_word ? sext_word(w_spec_sel[WLEN-1:0]) : w_spec_sel;

    assign w_sa    = w_sgn & w_a_eff[XLEN-1];
    assign w_sb    = w_sgn & w_b_eff[XLEN-1];
    assign w_mag_a = w_sa ? -w_a_eff : w_a_eff;
    assign w_mag_b = w_sb ? -w_b_eff : w_b_eff;

    div_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_nrem),
        .o_quo     (w_nquo)
    );

    // Sign fix-up and result selection for the normal path.
    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_fix_sel = is_rem(r_op) ? w_r_fix : w_q_fix;
    assign w_fix_res = is_word(r_op) ? sext_word(w_fix_sel[WLEN-1:0]) : w_fix_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= DIV;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        if (w_div0 || w_ovf) begin
                            r_c         <= w_spec_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            // Word dividends start in the upper half so 32 shifts consume them.
                            r_rem   <= '0;
                            r_quo   <= w_word ? {w_mag_a[WLEN-1:0], {WLEN{1'b0}}} : w_mag_a;
                            r_div   <= w_mag_b;
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                            r_cnt   <= w_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_nrem;
                    r_quo <= w_nquo;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_c         <= w_fix_res;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;

endmodule
